// File: rtl/mmu_credits_wr_mc.sv
// -----------------------------------------------------------------------------
// mmu_credits_wr_mc
//
// Multi-channel write-credit gate in front of the shared TLB/DMA write request
// port of a vFPGA. Each channel counts the write data beats already sitting in
// its data buffer. A request is forwarded only once all of its beats are
// buffered, so a stream that stalls on data never holds the shared port.
// Eligible channels are served round-robin. The granted channel ID is kept in
// an in-order FIFO so that completions can be routed back to their origin.
//
// Ports
//   aclk, aresetn        clock, asynchronous active-low reset
//   s_req_valid[c]       channel c request valid
//   s_req_ready[c]       channel c request accepted (grant or oversize drop)
//   s_req_vaddr/len/last channel c request fields, packed per channel
//   s_rsp_done[c]        completion routed back to channel c
//   m_req_valid/ready    shared request handshake
//   m_req_vaddr/len/last shared request fields (muxed from granted channel)
//   m_rsp_done           completion marker from the shared port
//   wxfer[c]             one pulse per data beat accepted into channel c buffer
//   cred                 per-channel credit count, CW bits per channel
//   err_ovf[c]           sticky: beat arrived while channel was full
//   err_size[c]          sticky: request larger than the buffer was dropped
//   err_cpl              sticky: completion arrived with nothing outstanding
// -----------------------------------------------------------------------------
module mmu_credits_wr_mc #(
    parameter int  ID_REG    = 0,
    parameter int  DATA_BITS = 512,
    parameter int  N_CHAN    = 4,
    parameter int  CRED_MAX  = 64,
    parameter int  CPL_DEPTH = 16,
    parameter int  ADDR_BITS = 48,
    parameter int  LEN_BITS  = 28,
    localparam int CW        = $clog2(CRED_MAX + 1)
) (
    input  logic                          aclk,
    input  logic                          aresetn,

    input  logic [N_CHAN-1:0]             s_req_valid,
    output logic [N_CHAN-1:0]             s_req_ready,
    input  logic [N_CHAN*ADDR_BITS-1:0]   s_req_vaddr,
    input  logic [N_CHAN*LEN_BITS-1:0]    s_req_len,
    input  logic [N_CHAN-1:0]             s_req_last,
    output logic [N_CHAN-1:0]             s_rsp_done,

    output logic                          m_req_valid,
    input  logic                          m_req_ready,
    output logic [ADDR_BITS-1:0]          m_req_vaddr,
    output logic [LEN_BITS-1:0]           m_req_len,
    output logic                          m_req_last,
    input  logic                          m_rsp_done,

    input  logic [N_CHAN-1:0]             wxfer,
    output logic [N_CHAN*CW-1:0]          cred,
    output logic [N_CHAN-1:0]             err_ovf,
    output logic [N_CHAN-1:0]             err_size,
    output logic                          err_cpl
);

    localparam int BL   = $clog2(DATA_BITS / 8);
    localparam int NB_W = LEN_BITS - BL + 1;
    localparam int IDW  = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
    localparam int PW   = (CPL_DEPTH > 1) ? $clog2(CPL_DEPTH) : 1;
    localparam logic [PW:0] CNT_FULL = (PW + 1)'(CPL_DEPTH);

    if (N_CHAN < 1 || ID_REG < 0 || CPL_DEPTH < 2 ||
        (CPL_DEPTH & (CPL_DEPTH - 1)) != 0) begin : g_param_err
        $error("mmu_credits_wr_mc: invalid parameter set");
    end

    // ------------------------------------------------------------------
    // Per-channel beat count and eligibility
    // ------------------------------------------------------------------
    logic [LEN_BITS:0]   len_up [N_CHAN];
    logic [NB_W-1:0]     nb     [N_CHAN];
    logic [CW-1:0]       cred_q [N_CHAN];
    logic [N_CHAN-1:0]   over;
    logic [N_CHAN-1:0]   elig;

    always_comb begin
        for (int c = 0; c < N_CHAN; c++) begin
            // ceil(len / bytes_per_beat) without a divider
            len_up[c] = {1'b0, s_req_len[c*LEN_BITS +: LEN_BITS]}
                      + (LEN_BITS + 1)'((2 ** BL) - 1);
            nb[c]     = len_up[c][LEN_BITS:BL];
            over[c]   = 32'(nb[c]) > 32'(CRED_MAX);
            elig[c]   = s_req_valid[c] && !over[c]
                        && (32'(cred_q[c]) >= 32'(nb[c]));
        end
    end

    // ------------------------------------------------------------------
    // Round-robin arbiter, combinational grant
    // ------------------------------------------------------------------
    logic [IDW-1:0]    rr_ptr;
    logic [IDW-1:0]    gidx;
    logic [IDW-1:0]    cand;
    logic [N_CHAN-1:0] grant;
    logic              found;
    logic              grant_any;
    logic              cpl_full;
    logic              cpl_empty;

    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base,
                                              input int offs);
        return IDW'((int'(base) + offs) % N_CHAN);
    endfunction

    always_comb begin
        grant = '0;
        gidx  = '0;
        cand  = '0;
        found = 1'b0;
        // A pop in this cycle does not free a slot until the next edge,
        // so a full FIFO blocks regardless of m_rsp_done.
        if (m_req_ready && !cpl_full) begin
            for (int i = 0; i < N_CHAN; i++) begin
                cand = rr_idx(rr_ptr, i);
                if (!found && elig[cand]) begin
                    found       = 1'b1;
                    gidx        = cand;
                    grant[cand] = 1'b1;
                end
            end
        end
    end

    assign grant_any   = |grant;
    // Oversize requests are acknowledged and discarded so they cannot wedge
    // the channel; several may be dropped in the same cycle.
    assign s_req_ready = grant | (s_req_valid & over);
    assign m_req_valid = grant_any;
    assign m_req_vaddr = s_req_vaddr[int'(gidx)*ADDR_BITS +: ADDR_BITS];
    assign m_req_len   = s_req_len[int'(gidx)*LEN_BITS +: LEN_BITS];
    assign m_req_last  = s_req_last[gidx];

    // ------------------------------------------------------------------
    // Credit update with saturation
    // ------------------------------------------------------------------
    logic [31:0]       cred_sum [N_CHAN];
    logic [CW-1:0]     cred_d   [N_CHAN];
    logic [N_CHAN-1:0] ovf_set;

    always_comb begin
        for (int c = 0; c < N_CHAN; c++) begin
            ovf_set[c]  = 1'b0;
            cred_sum[c] = 32'(cred_q[c])
                        - (grant[c] ? 32'(nb[c]) : 32'd0)
                        + {31'd0, wxfer[c]};
            if (cred_sum[c] > 32'(CRED_MAX)) begin
                cred_d[c]  = CW'(CRED_MAX);
                ovf_set[c] = 1'b1;
            end else begin
                cred_d[c]  = cred_sum[c][CW-1:0];
            end
        end
    end

    for (genvar c = 0; c < N_CHAN; c++) begin : g_cred_out
        assign cred[c*CW +: CW] = cred_q[c];
    end

    // ------------------------------------------------------------------
    // Completion ID FIFO
    // ------------------------------------------------------------------
    logic [IDW-1:0] cpl_mem [CPL_DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [PW:0]    cnt_q;
    logic [IDW-1:0] head;
    logic           pop;
    logic [N_CHAN-1:0] rsp_q;

    assign cpl_full  = (cnt_q == CNT_FULL);
    assign cpl_empty = (cnt_q == '0);
    assign head      = cpl_mem[rd_ptr];
    assign pop       = m_rsp_done && !cpl_empty;

    always_ff @(posedge aclk) begin
        if (grant_any) begin
            cpl_mem[wr_ptr] <= gidx;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int c = 0; c < N_CHAN; c++) begin
                cred_q[c] <= '0;
            end
            rr_ptr   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt_q    <= '0;
            rsp_q    <= '0;
            err_ovf  <= '0;
            err_size <= '0;
            err_cpl  <= 1'b0;
        end else begin
            for (int c = 0; c < N_CHAN; c++) begin
                cred_q[c] <= cred_d[c];
            end
            err_ovf  <= err_ovf | ovf_set;
            err_size <= err_size | (s_req_valid & over);
            err_cpl  <= err_cpl | (m_rsp_done && cpl_empty);

            if (grant_any) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= (gidx == IDW'(N_CHAN - 1)) ? '0 : gidx + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            cnt_q <= cnt_q + {{PW{1'b0}}, grant_any} - {{PW{1'b0}}, pop};

            rsp_q <= '0;
            if (pop) begin
                rsp_q[head] <= 1'b1;
            end
        end
    end

    assign s_rsp_done = rsp_q;

endmodule

// File: tb/tb_mmu_credits_wr_mc.sv
module tb_mmu_credits_wr_mc;

    localparam int N     = 4;
    localparam int CM    = 64;
    localparam int DEPTH = 4;
    localparam int DB    = 512;
    localparam int AB    = 32;
    localparam int LB    = 16;
    localparam int CW    = $clog2(CM + 1);
    localparam int BYTES = DB / 8;

    logic              aclk;
    logic              aresetn;
    logic [N-1:0]      s_req_valid;
    logic [N-1:0]      s_req_ready;
    logic [N*AB-1:0]   s_req_vaddr;
    logic [N*LB-1:0]   s_req_len;
    logic [N-1:0]      s_req_last;
    logic [N-1:0]      s_rsp_done;
    logic              m_req_valid;
    logic              m_req_ready;
    logic [AB-1:0]     m_req_vaddr;
    logic [LB-1:0]     m_req_len;
    logic              m_req_last;
    logic              m_rsp_done;
    logic [N-1:0]      wxfer;
    logic [N*CW-1:0]   cred;
    logic [N-1:0]      err_ovf;
    logic [N-1:0]      err_size;
    logic              err_cpl;

    mmu_credits_wr_mc #(
        .ID_REG(0), .DATA_BITS(DB), .N_CHAN(N), .CRED_MAX(CM),
        .CPL_DEPTH(DEPTH), .ADDR_BITS(AB), .LEN_BITS(LB)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
        .s_req_vaddr(s_req_vaddr), .s_req_len(s_req_len),
        .s_req_last(s_req_last), .s_rsp_done(s_rsp_done),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
        .m_req_vaddr(m_req_vaddr), .m_req_len(m_req_len),
        .m_req_last(m_req_last), .m_rsp_done(m_rsp_done),
        .wxfer(wxfer), .cred(cred), .err_ovf(err_ovf),
        .err_size(err_size), .err_cpl(err_cpl)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard types ----------------
    typedef struct {
        int          cyc;
        logic [AB-1:0] addr;
        int          len;
        bit          last;
    } gnt_t;

    typedef struct {
        logic [N-1:0]    ready;
        bit              mvalid;
        logic [N*CW-1:0] cred;
        logic [N-1:0]    ovf;
        logic [N-1:0]    size;
        bit              cpl;
    } st_t;

    typedef struct {
        int cyc;
        int ch;
    } rsp_t;

    gnt_t g_q[$];
    st_t  s_q[$];
    rsp_t r_q[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit mon_en = 0;

    // stimulus for the next cycle
    bit          t_v[N];
    int          t_len[N];
    logic [AB-1:0] t_addr[N];
    bit          t_last[N];
    bit          t_wx[N];
    bit          t_mready;
    bit          t_done;

    // reference model state
    int m_cred[N];
    int m_ptr;
    int m_q[$];
    bit m_ovf[N];
    bit m_size[N];
    bit m_cpl;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_cred[c] = 0;
            m_ovf[c]  = 0;
            m_size[c] = 0;
        end
        m_ptr = 0;
        m_cpl = 0;
        m_q.delete();
        g_q.delete();
        s_q.delete();
        r_q.delete();
    endtask

    task automatic idle();
        for (int c = 0; c < N; c++) begin
            t_v[c] = 0; t_len[c] = 0; t_addr[c] = '0;
            t_last[c] = 0; t_wx[c] = 0;
        end
        t_mready = 0;
        t_done   = 0;
    endtask

    task automatic apply();
        for (int c = 0; c < N; c++) begin
            s_req_valid[c]            = t_v[c];
            s_req_len[c*LB +: LB]     = LB'(t_len[c]);
            s_req_vaddr[c*AB +: AB]   = t_addr[c];
            s_req_last[c]             = t_last[c];
            wxfer[c]                  = t_wx[c];
        end
        m_req_ready = t_mready;
        m_rsp_done  = t_done;
    endtask

    // One clock cycle: drive stimulus, predict, push expectations.
    task automatic step();
        int   nb[N];
        bit   over[N];
        int   g;
        int   c;
        int   nv;
        st_t  st;
        gnt_t ge;
        rsp_t re;
        @(posedge aclk);
        #1;
        cyc++;
        apply();
        g = -1;
        st.ready = '0;
        for (int k = 0; k < N; k++) begin
            nb[k]   = (t_len[k] + BYTES - 1) / BYTES;
            over[k] = nb[k] > CM;
            if (t_v[k] && over[k]) st.ready[k] = 1'b1;
        end
        if (t_mready && m_q.size() < DEPTH) begin
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (g < 0 && t_v[c] && !over[c] && m_cred[c] >= nb[c]) g = c;
            end
        end
        if (g >= 0) begin
            st.ready[g] = 1'b1;
            ge.cyc  = cyc;
            ge.addr = t_addr[g];
            ge.len  = t_len[g];
            ge.last = t_last[g];
            g_q.push_back(ge);
        end
        st.mvalid = (g >= 0);
        for (int k = 0; k < N; k++) begin
            st.cred[k*CW +: CW] = CW'(m_cred[k]);
            st.ovf[k]  = m_ovf[k];
            st.size[k] = m_size[k];
        end
        st.cpl = m_cpl;
        s_q.push_back(st);

        if (t_done) begin
            if (m_q.size() > 0) begin
                re.cyc = cyc + 1;
                re.ch  = m_q.pop_front();
                r_q.push_back(re);
            end else begin
                m_cpl = 1;
            end
        end
        if (g >= 0) begin
            m_q.push_back(g);
            m_ptr = (g + 1) % N;
        end
        for (int k = 0; k < N; k++) begin
            nv = m_cred[k] - ((k == g) ? nb[k] : 0) + (t_wx[k] ? 1 : 0);
            if (nv > CM) begin
                nv = CM;
                m_ovf[k] = 1;
            end
            m_cred[k] = nv;
            if (t_v[k] && over[k]) m_size[k] = 1;
        end
        mon_en = 1;
    endtask

    // ---------------- monitor ----------------
    initial begin
        st_t  st;
        gnt_t ge;
        rsp_t re;
        forever begin
            @(negedge aclk);
            if (mon_en) begin
                if (s_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL state_q: no expected state at cycle %0d", cyc);
                end else begin
                    st = s_q.pop_front();
                    chk("s_req_ready", 64'(s_req_ready), 64'(st.ready));
                    chk("m_req_valid", 64'(m_req_valid), 64'(st.mvalid));
                    chk("cred",        64'(cred),        64'(st.cred));
                    chk("err_ovf",     64'(err_ovf),     64'(st.ovf));
                    chk("err_size",    64'(err_size),    64'(st.size));
                    chk("err_cpl",     64'(err_cpl),     64'(st.cpl));
                end
                if (m_req_valid) begin
                    if (g_q.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL grant: unexpected m_req_valid at cycle %0d", cyc);
                    end else begin
                        ge = g_q.pop_front();
                        chk("gnt_cycle", 64'(cyc),         64'(ge.cyc));
                        chk("gnt_addr",  64'(m_req_vaddr), 64'(ge.addr));
                        chk("gnt_len",   64'(m_req_len),   64'(ge.len));
                        chk("gnt_last",  64'(m_req_last),  64'(ge.last));
                    end
                end
                if (|s_rsp_done) begin
                    if (r_q.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL rsp: unexpected s_rsp_done %0h at cycle %0d",
                                 s_rsp_done, cyc);
                    end else begin
                        re = r_q.pop_front();
                        chk("rsp_cycle", 64'(cyc),        64'(re.cyc));
                        chk("rsp_chan",  64'(s_rsp_done), 64'(1 << re.ch));
                    end
                end
            end
        end
    end

    // Reset asserted between edges; outputs must clear immediately.
    task automatic do_reset();
        @(posedge aclk);
        #3;
        mon_en = 0;
        aresetn = 1'b0;
        idle();
        apply();
        #1;
        chk("rst_cred",     64'(cred),        64'd0);
        chk("rst_err_ovf",  64'(err_ovf),     64'd0);
        chk("rst_err_size", 64'(err_size),    64'd0);
        chk("rst_err_cpl",  64'(err_cpl),     64'd0);
        chk("rst_rsp",      64'(s_rsp_done),  64'd0);
        chk("rst_m_valid",  64'(m_req_valid), 64'd0);
        chk("rst_s_ready",  64'(s_req_ready), 64'd0);
        model_reset();
        repeat (2) @(posedge aclk);
        #2;
        aresetn = 1'b1;
    endtask

    task automatic drain();
        for (int k = 0; k < 2 * DEPTH && m_q.size() > 0; k++) begin
            idle();
            t_done = 1;
            step();
        end
        idle();
        step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int r;
        aresetn = 1'b0;
        idle();
        apply();
        model_reset();
        do_reset();

        // all four channels eligible: round-robin order from pointer 0
        idle();
        for (int c = 0; c < N; c++) t_wx[c] = 1;
        repeat (4) step();
        for (int k = 0; k < 9; k++) begin
            idle();
            t_mready = 1;
            t_done   = (m_q.size() > 0);
            for (int c = 0; c < N; c++) begin
                t_v[c]    = (k < 5) || (c != 1);
                t_len[c]  = 64;
                t_addr[c] = AB'(32'h1000 * (c + 1) + k);
            end
            step();
        end
        drain();

        // 4-beat request: no grant until the 4th beat is visible
        idle();
        for (int k = 0; k < 5; k++) begin
            t_v[0] = 1; t_len[0] = 256; t_addr[0] = 32'hA000_0000;
            t_mready = 1;
            t_wx[0] = (k < 4);
            step();
        end
        idle();
        step();

        // grant and wxfer on the same channel in the same cycle
        idle();
        t_wx[2] = 1;
        repeat (2) step();
        t_v[2] = 1; t_len[2] = 100; t_addr[2] = 32'hB000_0000;
        t_mready = 1;
        step();
        idle();
        step();
        drain();

        // completion FIFO full blocks grants; a pop frees it next cycle
        for (int k = 0; k < 7; k++) begin
            idle();
            t_mready = 1;
            t_done   = (k == 5);
            for (int c = 0; c < N; c++) begin
                t_v[c] = 1; t_len[c] = 0; t_addr[c] = AB'(k * 16 + c);
            end
            step();
        end
        drain();

        // saturation and oversize drop
        idle();
        t_wx[3] = 1;
        repeat (CM + 3) step();
        idle();
        t_v[1] = 1; t_len[1] = 65 * 64; t_addr[1] = 32'hC000_0000;
        t_mready = 1;
        step();
        idle();
        step();

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            idle();
            for (int c = 0; c < N; c++) begin
                t_v[c] = ($urandom_range(0, 99) < 50);
                r = $urandom_range(0, 99);
                if (r < 10)      t_len[c] = 0;
                else if (r < 14) t_len[c] = $urandom_range(CM * BYTES + 1, 65535);
                else if (r < 18) t_len[c] = CM * BYTES;
                else             t_len[c] = $urandom_range(1, 1024);
                t_addr[c] = AB'($urandom);
                t_last[c] = ($urandom_range(0, 1) == 1);
                t_wx[c]   = ($urandom_range(0, 99) < 60);
            end
            t_mready = ($urandom_range(0, 99) < 75);
            t_done   = ($urandom_range(0, 99) < 30);
            step();
        end
        drain();

        // mid-traffic reset with credits and outstanding completions
        idle();
        t_wx[0] = 1;
        repeat (5) step();
        for (int k = 0; k < 3; k++) begin
            idle();
            t_v[1] = 1; t_len[1] = 0; t_addr[1] = AB'(k);
            t_mready = 1;
            step();
        end
        do_reset();
        idle();
        t_done = 1;
        step();
        idle();
        repeat (2) step();

        @(negedge aclk);
        #1;
        mon_en = 0;
        chk("left_grants", 64'(g_q.size()), 64'd0);
        chk("left_rsps",   64'(r_q.size()), 64'd0);
        chk("left_states", 64'(s_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mmu_credits_wr_mc.md
# mmu_credits_wr_mc

Multi-channel write-credit gate between N_CHAN per-stream write request queues of a vFPGA and the shared TLB/DMA write request port. Each channel holds a beat-credit counter fed by that channel's write data transfers. A request is forwarded only once all of its beats are buffered, so a stalled stream cannot block the shared port. Forwarded requests are arbitrated round-robin, and completions are routed back to the originating channel through an in-order completion ID FIFO.

## Interface

Parameters
- ID_REG, 0, number of the associated vFPGA.
- DATA_BITS, AXI_DATA_BITS, data bus width.
- N_CHAN, 4, number of request channels (≥1).
- CRED_MAX, 64, per-channel buffer depth in beats; credit counter saturation value.
- CPL_DEPTH, 16, completion ID FIFO depth (power of 2).

Ports
- aclk  in  1  clock.
- aresetn  in  1  reset, asynchronous, active-low.
- s_req[N_CHAN]  dmaIntf.s  array  per-channel requests in; rsp driven back per channel.
- m_req  dmaIntf.m  1  shared request out; m_req.rsp carries completions (done marker: m_req.rsp.done).
- wxfer  in  N_CHAN  one-cycle pulse per beat accepted into channel c's data buffer.
- cred  out  N_CHAN*CW  current credit count per channel; CW = $clog2(CRED_MAX+1).
- err_ovf  out  N_CHAN  sticky: wxfer arrived while the channel was at CRED_MAX.
- err_size  out  N_CHAN  sticky: a request needing more than CRED_MAX beats was dropped.
- err_cpl  out  1  sticky: done received while the completion FIFO was empty.

## Operation

- BEAT_LOG_BITS = $clog2(DATA_BITS/8).
- n_beats[c] = ceil(len / (DATA_BITS/8)), computed as (len + 2^BEAT_LOG_BITS − 1) >> BEAT_LOG_BITS, width LEN_BITS−BEAT_LOG_BITS+1.
- len = 0 gives 0 beats and is forwarded without consuming credit.
- Eligible[c] = s_req[c].valid && cred[c] ≥ n_beats[c] && n_beats[c] ≤ CRED_MAX.
- Oversize (n_beats > CRED_MAX):
  - s_req[c].ready = 1 for one cycle; the request is dropped and err_size[c] is set.
  - It does not take part in arbitration.
  - Several oversize channels may all be dropped in the same cycle.
- Arbiter: round-robin over eligible channels, starting at the channel after the last grant; pointer reset value 0.
- Grant conditions: at most one grant per cycle, and only when m_req.ready && !cpl_full.
- On a grant to channel g:
  - m_req.valid = 1, m_req.req = s_req[g].req, s_req[g].ready = 1.
  - Channel ID g is pushed to the completion FIFO.
- Credit update per channel, every cycle:
  - next = cred − (granted ? n_beats : 0) + (wxfer ? 1 : 0).
  - Result saturates at CRED_MAX; if an increment is lost to saturation, err_ovf[c] is set.
  - A grant and a wxfer on the same channel in the same cycle both apply (net −n_beats+1).
  - The result never underflows, because a grant requires cred ≥ n_beats.
- Completion routing:
  - When m_req.rsp.done is set, the FIFO head is popped and the completion goes to that channel only.
  - s_req[head].rsp <= m_req.rsp on the next edge. All other channels' rsp <= 0.
  - With m_req.rsp.done = 0, every s_req[c].rsp <= 0.
  - done with an empty FIFO sets err_cpl; nothing is routed.
- When the FIFO is full, all grants are blocked.
  - A pop in the same cycle does not unblock; the push is allowed from the next cycle.
- A push and a pop in the same cycle (FIFO not full) are both performed; the count is unchanged.

## Timing

- Grant path is combinational: s_req.ready and m_req.valid go high in the same cycle as the eligibility check. No req register stage.
- Credits, the arbitration pointer, the FIFO and the error flags update on the rising aclk edge.
- Credit added by a wxfer in cycle t is visible to eligibility in cycle t+1.
- Completion latency: done at m_req in cycle t gives s_req[head].rsp in cycle t+1.
- Reset (aresetn low, asynchronous, any time including mid-burst) clears:
  - cred to 0, pointer to 0, FIFO empty;
  - all rsp to 0, all err_* to 0.
  - With no valid inputs, m_req.valid and all s_req.ready are 0 (both are combinational).
- Requests in flight at reset are forgotten; later dones set err_cpl.

## Test plan

- Single channel, DATA_BITS=512, len=256 (4 beats): 3 wxfer pulses → no grant; 4th pulse → grant in the next cycle, cred becomes 0.
- len=100 (ceil gives 2 beats), cred=2, grant and wxfer in the same cycle → cred=1 afterwards.
- 4 channels all eligible, m_req.ready=1 → grants in order 0,1,2,3,0. Drop channel 1's valid → order 2,3,0,2.
- CPL_DEPTH=2: two grants with no done → third channel held off (ready=0). Done pulse → s_req[first].rsp asserted 1 cycle later; the third grant happens in the following cycle.
- cred=CRED_MAX with wxfer → cred stays 64, err_ovf[c]=1. Request len=65·64 B → ready pulse, no m_req.valid, err_size[c]=1.
- Assert aresetn low mid-traffic (cred=5, FIFO count=3) → all state 0 immediately. A done after release → err_cpl=1, no rsp on any channel.
